// File: rtl/pcie_c2h_dsc_ring.sv
// C2H descriptor-bypass stage: one descriptor per packet into the next host ring slot,
// then a zero-latency beat pass-through with slot-size truncation and host flow control.
module pcie_c2h_dsc_ring #(
  parameter int          DATA_WIDTH = 256,
  parameter logic [63:0] RING_BASE  = 64'h1_0000_0000,
  parameter int          SLOT_BYTES = 4096,
  parameter int          NUM_SLOTS  = 256,
  parameter int          IDX_W      = 16
) (
  input  logic                    user_clk_250,
  input  logic                    user_reset_250,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    dsc_load,
  input  logic                    dsc_ready,
  output logic [63:0]             dsc_dst_addr,
  output logic [63:0]             dsc_src_addr,
  output logic [27:0]             dsc_len,
  output logic [15:0]             dsc_ctl,
  input  logic [IDX_W-1:0]        cons_idx,
  output logic [IDX_W-1:0]        prod_idx,
  output logic [15:0]             ovf_cnt
);

  localparam int MAX_BEATS  = SLOT_BYTES / (DATA_WIDTH / 8);
  localparam int BEAT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int SLOT_SHIFT = $clog2(SLOT_BYTES);

  typedef enum logic [1:0] {IDLE, DSC, DATA, DROP} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  prod_idx_q, prod_idx_d;
  logic [15:0]       ovf_cnt_q, ovf_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [IDX_W-1:0]  occupancy;
  logic              full;
  logic [SLOT_W-1:0] slot;
  logic              last_slot_beat;
  logic              beat_acc;

  // Modular occupancy keeps the full test correct across index wrap.
  assign occupancy      = prod_idx_q - cons_idx;
  assign full           = occupancy >= IDX_W'(NUM_SLOTS);
  assign slot           = prod_idx_q[SLOT_W-1:0];
  assign last_slot_beat = beat_cnt_q == BEAT_W'(MAX_BEATS - 1);
  assign beat_acc       = s_tvalid && m_tready;

  assign dsc_load     = state_q == DSC;
  assign dsc_dst_addr = RING_BASE + (64'(slot) << SLOT_SHIFT);
  assign dsc_src_addr = 64'd0;
  assign dsc_len      = 28'(SLOT_BYTES);
  assign dsc_ctl      = 16'd0;

  assign m_tvalid = (state_q == DATA) && s_tvalid;
  assign m_tlast  = (state_q == DATA) && (s_tlast || last_slot_beat);
  assign m_tdata  = s_tdata;
  assign m_tkeep  = s_tkeep;
  assign s_tready = (state_q == DATA) ? m_tready : (state_q == DROP);

  assign prod_idx = prod_idx_q;
  assign ovf_cnt  = ovf_cnt_q;

  always_comb begin
    state_d    = state_q;
    prod_idx_d = prod_idx_q;
    ovf_cnt_d  = ovf_cnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (s_tvalid && !full) state_d = DSC;
      end
      DSC: begin
        if (dsc_ready) state_d = DATA;
      end
      DATA: begin
        if (beat_acc) begin
          if (s_tlast) begin
            prod_idx_d = prod_idx_q + 1'b1;
            state_d    = IDLE;
          end else if (last_slot_beat) begin
            prod_idx_d = prod_idx_q + 1'b1;
            if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
            state_d    = DROP;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      DROP: begin
        if (s_tvalid && s_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk_250) begin
    if (user_reset_250) begin
      state_q    <= IDLE;
      prod_idx_q <= '0;
      ovf_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prod_idx_q <= prod_idx_d;
      ovf_cnt_q  <= ovf_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_pcie_c2h_dsc_ring.sv
// Scoreboard bench for pcie_c2h_dsc_ring: a packet-level model queues the expected
// descriptors and beats; an independent monitor pops and compares what the DUT emits.
module tb_pcie_c2h_dsc_ring;

  localparam logic [63:0] RING_BASE = 64'h1_0000_0000;
  localparam int SLOTB = 4096;
  localparam int NSLOT = 256;
  localparam int MAXB  = 128;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_tvalid, s_tready, s_tlast;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic         m_tvalid, m_tready, m_tlast;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic         dsc_load, dsc_ready;
  logic [63:0]  dsc_dst_addr, dsc_src_addr;
  logic [27:0]  dsc_len;
  logic [15:0]  dsc_ctl;
  logic [15:0]  cons_idx, prod_idx, ovf_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  beat_t       exp_beats[$];
  logic [63:0] exp_dsc[$];
  logic [15:0] model_prod;
  logic [15:0] model_ovf;
  bit  mon_en = 1'b0;
  bit  tready_rand = 1'b0;
  bit  dsc_rand = 1'b0;
  int  dsc_hi_cycles = 0;

  pcie_c2h_dsc_ring dut (
    .user_clk_250  (clk),
    .user_reset_250(rst),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tlast       (s_tlast),
    .s_tdata       (s_tdata),
    .s_tkeep       (s_tkeep),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tlast       (m_tlast),
    .m_tdata       (m_tdata),
    .m_tkeep       (m_tkeep),
    .dsc_load      (dsc_load),
    .dsc_ready     (dsc_ready),
    .dsc_dst_addr  (dsc_dst_addr),
    .dsc_src_addr  (dsc_src_addr),
    .dsc_len       (dsc_len),
    .dsc_ctl       (dsc_ctl),
    .cons_idx      (cons_idx),
    .prod_idx      (prod_idx),
    .ovf_cnt       (ovf_cnt)
  );

  always #2 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: got event expected none", name);
  endtask

  function automatic logic [63:0] slotAddr(input logic [15:0] p);
    return RING_BASE + 64'((int'(p) % NSLOT) * SLOTB);
  endfunction

  // Output monitor: pops the scoreboard on every real transfer.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (dsc_load) dsc_hi_cycles++;
      if (m_tvalid && m_tready) begin
        if (exp_beats.size() == 0) reportFail("unexpected_beat");
        else begin
          beat_t e;
          e = exp_beats.pop_front();
          checkOutput("beat_data", m_tdata, e.d);
          checkOutput("beat_keep", 256'(m_tkeep), 256'(e.k));
          checkOutput("beat_last", 256'(m_tlast), 256'(e.l));
        end
      end
      if (dsc_load && dsc_ready) begin
        if (exp_dsc.size() == 0) reportFail("unexpected_dsc");
        else begin
          checkOutput("dsc_dst_addr", 256'(dsc_dst_addr), 256'(exp_dsc.pop_front()));
          checkOutput("dsc_len", 256'(dsc_len), 256'(SLOTB));
          checkOutput("dsc_src_ctl", 256'({dsc_src_addr, dsc_ctl}), 256'(0));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tready_rand) m_tready = 1'($urandom_range(0, 1));
      if (dsc_rand) dsc_ready = 1'($urandom_range(0, 1));
    end
  end

  // Sends one packet; stall>0 means the ring is expected full for that many cycles,
  // after which the host consumer index is advanced by one.
  task automatic applyStimulus(input int nbeats, input int stall);
    beat_t b[$];
    int t;
    for (int i = 0; i < nbeats; i++) begin
      beat_t x;
      x.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      x.k = $urandom;
      x.l = (i == nbeats - 1);
      b.push_back(x);
    end
    exp_dsc.push_back(slotAddr(model_prod));
    for (int i = 0; i < nbeats && i < MAXB; i++) begin
      beat_t e;
      e = b[i];
      e.l = (i == nbeats - 1) || (i == MAXB - 1);
      exp_beats.push_back(e);
    end
    model_prod = model_prod + 16'd1;
    if (nbeats > MAXB && model_ovf != 16'hFFFF) model_ovf = model_ovf + 16'd1;
    for (int i = 0; i < nbeats; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = b[i].d;
      s_tkeep  = b[i].k;
      s_tlast  = b[i].l;
      if (i == 0 && stall > 0) begin
        repeat (stall) begin
          @(negedge clk);
          checkOutput("full_stall_load", 256'(dsc_load), 256'(0));
          checkOutput("full_stall_ready", 256'(s_tready), 256'(0));
        end
        cons_idx = cons_idx + 16'd1;
      end
      t = 0;
      forever begin
        @(negedge clk);
        if (s_tready) break;
        t++;
        if (t > 5000) begin
          reportFail("beat_accept_timeout");
          s_tvalid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    checkOutput("prod_idx", 256'(prod_idx), 256'(model_prod));
    checkOutput("ovf_cnt", 256'(ovf_cnt), 256'(model_ovf));
  endtask

  task automatic doReset();
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_dsc_load", 256'(dsc_load), 256'(0));
    checkOutput("rst_m_tvalid", 256'(m_tvalid), 256'(0));
    checkOutput("rst_m_tlast", 256'(m_tlast), 256'(0));
    checkOutput("rst_s_tready", 256'(s_tready), 256'(0));
    checkOutput("rst_prod_idx", 256'(prod_idx), 256'(0));
    checkOutput("rst_ovf_cnt", 256'(ovf_cnt), 256'(0));
    rst = 1'b0;
    exp_beats.delete();
    exp_dsc.delete();
    model_prod = 16'd0;
    model_ovf = 16'd0;
  endtask

  initial begin
    logic [63:0] held_addr;
    int t;
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tdata = '0;
    s_tkeep = '0;
    m_tready = 1'b1;
    dsc_ready = 1'b1;
    cons_idx = 16'd0;
    doReset();
    mon_en = 1'b1;

    $display("[TB] single 4-beat packet");
    dsc_hi_cycles = 0;
    applyStimulus(4, 0);
    checkOutput("dsc_load_cycles", 256'(dsc_hi_cycles), 256'(1));

    $display("[TB] ring fill and full stall");
    doReset();
    cons_idx = 16'd0;
    for (int n = 0; n < NSLOT; n++) applyStimulus(1, 0);
    applyStimulus(1, 20);

    $display("[TB] truncation and exact-fit packets");
    cons_idx = model_prod;
    applyStimulus(130, 0);
    applyStimulus(128, 0);
    applyStimulus(129, 0);

    $display("[TB] descriptor backpressure");
    dsc_ready = 1'b0;
    held_addr = slotAddr(model_prod);
    fork
      applyStimulus(4, 0);
      begin
        t = 0;
        while (!dsc_load && t < 100) begin
          @(negedge clk);
          t++;
        end
        repeat (10) begin
          checkOutput("dsc_hold_load", 256'(dsc_load), 256'(1));
          checkOutput("dsc_hold_addr", 256'(dsc_dst_addr), 256'(held_addr));
          checkOutput("dsc_hold_mvalid", 256'(m_tvalid), 256'(0));
          @(negedge clk);
        end
        dsc_ready = 1'b1;
      end
    join

    $display("[TB] randomized traffic with backpressure");
    tready_rand = 1'b1;
    dsc_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      cons_idx = model_prod - 16'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) applyStimulus(int'($urandom_range(126, 132)), 0);
      else applyStimulus(int'($urandom_range(1, 6)), 0);
    end
    tready_rand = 1'b0;
    dsc_rand = 1'b0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    dsc_ready = 1'b1;
    checkOutput("queues_drained", 256'(exp_beats.size() + exp_dsc.size()), 256'(0));

    $display("[TB] reset mid-packet");
    mon_en = 1'b0;
    cons_idx = model_prod;
    s_tvalid = 1'b1;
    s_tlast = 1'b0;
    s_tdata = '1;
    t = 0;
    while (!(dut.m_tvalid && m_tready) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_m_tvalid", 256'(m_tvalid), 256'(0));
    checkOutput("midrst_m_tlast", 256'(m_tlast), 256'(0));
    checkOutput("midrst_dsc_load", 256'(dsc_load), 256'(0));
    checkOutput("midrst_s_tready", 256'(s_tready), 256'(0));
    checkOutput("midrst_prod_idx", 256'(prod_idx), 256'(0));
    checkOutput("midrst_ovf_cnt", 256'(ovf_cnt), 256'(0));
    s_tvalid = 1'b0;
    rst = 1'b0;
    exp_beats.delete();
    exp_dsc.delete();
    model_prod = 16'd0;
    model_ovf = 16'd0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    $display("[TB] producer index wrap");
    force dut.prod_idx_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.prod_idx_q;
    cons_idx = 16'hFFFF;
    model_prod = 16'hFFFF;
    applyStimulus(2, 0);
    applyStimulus(3, 0);
    checkOutput("wrap_prod_idx", 256'(prod_idx), 256'(16'h0001));

    repeat (4) @(posedge clk);
    checkOutput("final_queues_drained", 256'(exp_beats.size() + exp_dsc.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
